controle_posicionamento: RTL
============================

Name: controle_posicionamento

Overview:
- Sequencer for the ship-placement phase of Batalha Naval.
- Walks the fixed 11-ship fleet for jogador 0, then for jogador 1. For each ship it presents tipo to the piece validator, fires its enable, and waits for either a memory write strobe (accepted) or a conflict flag (rejected).
- Sits between the user-input FSM (coordinates and confirm button) and the validator/memory pair. Drives the game FSM's "placement finished" signal.

Parameters:
- N_NAVIOS, 11: ships per player; equals the validator's memory depth.
- TIMEOUT, 64: cycles to wait in AGUARDA before declaring a timeout error.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- inicio  input  1  level; starts/restarts placement when sampled high in IDLE or FIM
- confirma  input  1  user confirm button, synchronous level; internally rising-edge detected
- val_conflito_borda  input  1  validator border-conflict flag
- val_conflito_memoria  input  1  validator memory-conflict flag
- val_wrep1  input  1  validator write strobe, player 0 memory
- val_wrep2  input  1  validator write strobe, player 1 memory
- val_enable  output  1  one-cycle enable pulse to validator
- tipo  output  3  ship type for current index
- jogador  output  1  current player
- navio_idx  output  4  current fleet index, 0..N_NAVIOS-1
- erro  output  1  rejected placement (conflict or timeout)
- erro_timeout  output  1  set together with erro when the cause was timeout
- fim_posicionamento  output  1  both fleets placed
- estado  output  3  FSM state code, for debug LEDs

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - val_enable, erro, erro_timeout, fim_posicionamento, jogador = 0.
  - navio_idx = 0, tipo = 0.
  - timeout counter and confirm edge register cleared.
- tipo is combinational from navio_idx:
  - idx 0 → 0 (porta-aviões)
  - 1-2 → 1 (encouraçado)
  - 3-4 → 2 (hidroavião)
  - 5-7 → 3 (cruzador)
  - 8-10 → 4 (submarino)
  - 11-15 → 4 (unreachable)
- Confirm edge: conf_pulse = confirma & ~confirma_d (one cycle). Held buttons do not retrigger.
- States: IDLE=0, ESPERA_CONF=1, DISPARA=2, AGUARDA=3, ERRO=4, PROX=5, FIM=6.
- IDLE: inicio=1 → ESPERA_CONF. jogador and navio_idx are set to 0.
- ESPERA_CONF: conf_pulse → DISPARA.
- DISPARA: val_enable=1 for exactly this cycle. The timeout counter is cleared. Next state is AGUARDA.
- AGUARDA: timeout counter increments each cycle. Transitions are evaluated in priority order:
  1. Either conflict flag high → ERRO; erro=1 registered.
  2. Else the wrep strobe matching jogador (val_wrep1 when jogador=0, val_wrep2 when jogador=1) high → PROX.
  3. Else counter == TIMEOUT-1 → ERRO; erro=1 and erro_timeout=1.
  - A wrep for the wrong player is ignored.
  - Conflict and wrep in the same cycle: conflict wins.
- ERRO: erro held high.
  - conf_pulse → DISPARA (retry of the same navio_idx), with erro and erro_timeout cleared on that transition.
  - inicio is ignored in ERRO.
- PROX: one cycle.
  - If navio_idx < N_NAVIOS-1: navio_idx+1 → ESPERA_CONF.
  - Else if jogador=0: jogador=1, navio_idx=0 → ESPERA_CONF.
  - Else → FIM.
- FIM: fim_posicionamento=1; navio_idx and jogador hold their final values.
  - inicio=1 → IDLE behaviour: fim cleared, indices zeroed, next state ESPERA_CONF.
- val_enable is never high for two consecutive cycles. It is high only in DISPARA.
- Total accepted placements before FIM is exactly 2·N_NAVIOS.
- Reset mid-operation returns to IDLE immediately. A val_enable pulse in progress is dropped.

Test Plan:
- Reset, inicio=1, confirm pulse, wrep1 3 cycles after val_enable → single val_enable pulse, tipo=0, navio_idx steps 0→1, tipo=1, state ESPERA_CONF.
- 22 confirm/wrep rounds (wrep1 for the first 11, wrep2 for the next 11) → tipo sequence 0,1,1,2,2,3,3,3,4,4,4 twice; jogador flips after the 11th; fim_posicionamento=1 after the 22nd.
- Border conflict at idx 3 → erro=1, erro_timeout=0, idx stays 3. Confirm → new val_enable, erro=0. wrep1 → idx 4.
- No response for 64 cycles after val_enable → erro=1 and erro_timeout=1 at cycle 64. Retry plus wrep1 advances normally.
- val_conflito_memoria and val_wrep1 high in the same cycle → ERRO, idx unchanged. wrep2 alone while jogador=0 → ignored, eventual timeout.
- confirma held high 20 cycles → one val_enable only. rst_n low during AGUARDA → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/controle_posicionamento.sv
// Ship-placement sequencer for Batalha Naval: walks each player's fleet, fires the
// piece validator once per ship and waits for a memory write, a conflict or a timeout.
//
// state        | meaning
// IDLE         | waiting for inicio
// ESPERA_CONF  | waiting for the user to confirm the current ship
// DISPARA      | one-cycle validator enable, timeout counter cleared
// AGUARDA      | waiting for wrep / conflict / timeout
// ERRO         | placement rejected, waiting for confirm to retry
// PROX         | advance to next ship or player
// FIM          | both fleets placed
module controle_posicionamento #(
  parameter int N_NAVIOS = 11,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic       confirma,
  input  logic       val_conflito_borda,
  input  logic       val_conflito_memoria,
  input  logic       val_wrep1,
  input  logic       val_wrep2,
  output logic       val_enable,
  output logic [2:0] tipo,
  output logic       jogador,
  output logic [3:0] navio_idx,
  output logic       erro,
  output logic       erro_timeout,
  output logic       fim_posicionamento,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ESPERA_CONF = 3'd1,
    DISPARA     = 3'd2,
    AGUARDA     = 3'd3,
    ERRO        = 3'd4,
    PROX        = 3'd5,
    FIM         = 3'd6
  } estado_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  estado_t         state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic            jog_q, jog_d;
  logic            erro_q, erro_d;
  logic            erro_t_q, erro_t_d;
  logic            confirma_q;
  logic            conf_pulse;
  logic            wrep_ok;

  assign conf_pulse = confirma & ~confirma_q;
  // A write strobe for the other player's memory is not an acceptance.
  assign wrep_ok    = jog_q ? val_wrep2 : val_wrep1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      jog_q      <= 1'b0;
      erro_q     <= 1'b0;
      erro_t_q   <= 1'b0;
      confirma_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      jog_q      <= jog_d;
      erro_q     <= erro_d;
      erro_t_q   <= erro_t_d;
      confirma_q <= confirma;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    jog_d    = jog_q;
    erro_d   = erro_q;
    erro_t_d = erro_t_q;
    case (state_q)
      IDLE, FIM: begin
        if (inicio) begin
          idx_d   = '0;
          jog_d   = 1'b0;
          state_d = ESPERA_CONF;
        end
      end
      ESPERA_CONF: begin
        if (conf_pulse) state_d = DISPARA;
      end
      DISPARA: begin
        cnt_d   = '0;
        state_d = AGUARDA;
      end
      AGUARDA: begin
        cnt_d = cnt_q + CW'(1);
        if (val_conflito_borda || val_conflito_memoria) begin
          erro_d  = 1'b1;
          state_d = ERRO;
        end else if (wrep_ok) begin
          state_d = PROX;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          erro_d   = 1'b1;
          erro_t_d = 1'b1;
          state_d  = ERRO;
        end
      end
      ERRO: begin
        if (conf_pulse) begin
          erro_d   = 1'b0;
          erro_t_d = 1'b0;
          state_d  = DISPARA;
        end
      end
      PROX: begin
        if (idx_q < 4'(N_NAVIOS - 1)) begin
          idx_d   = idx_q + 4'd1;
          state_d = ESPERA_CONF;
        end else if (!jog_q) begin
          jog_d   = 1'b1;
          idx_d   = '0;
          state_d = ESPERA_CONF;
        end else begin
          state_d = FIM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      4'd0:             tipo = 3'd0;
      4'd1, 4'd2:       tipo = 3'd1;
      4'd3, 4'd4:       tipo = 3'd2;
      4'd5, 4'd6, 4'd7: tipo = 3'd3;
      default:          tipo = 3'd4;
    endcase
  end

  assign val_enable         = (state_q == DISPARA);
  assign fim_posicionamento = (state_q == FIM);
  assign jogador            = jog_q;
  assign navio_idx          = idx_q;
  assign erro               = erro_q;
  assign erro_timeout       = erro_t_q;
  assign estado             = state_q;

endmodule
